// File: rtl/mem_responder.sv
// Data-memory responder: alignment check, programmable wait states, then a
// byte/half/word access on an internal RAM. Define MEM_RESP_INIT_EN to zero the RAM after reset.
module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_mem,
  input  logic [1:0]        W_R_mem,
  input  logic [1:0]        wordsize_mem,
  input  logic              sign_mem,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [31:0]       wdata_mem,
  output logic [31:0]       rdata_mem,
  output logic              busy_mem,
  output logic              done_mem,
  output logic              aligned_mem
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [3:0] LAT = 4'(LATENCY);

`ifdef MEM_RESP_INIT_EN
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, HOLD, INIT} state_t;
  localparam state_t RESET_STATE = INIT;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  logic [IDX_W-1:0] init_idx;
`else
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, HOLD} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        wr_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              load_rdata;
  logic [3:0]        ram_be;
  logic [IDX_W-1:0]  ram_idx;
  logic [31:0]       ram_wd;
  logic [31:0]       mem [DEPTH];

  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic [31:0] wd_rep;
  logic [3:0]  wr_be;

  always_comb begin
    case (wordsize_mem)
      2'b00:   aligned_mem = 1'b1;
      2'b01:   aligned_mem = ~addr_mem[0];
      default: aligned_mem = (addr_mem[1:0] == 2'b00);
    endcase
  end

  // Lane extraction/replication always works from the captured request fields.
  always_comb begin
    rd_word = mem[addr_q[ADDR_W-1:2]];
    rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00: begin
        rd_ext = {{24{sign_q & rd_byte[7]}}, rd_byte};
        wd_rep = {4{wdata_q[7:0]}};
        wr_be  = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        rd_ext = {{16{sign_q & rd_half[15]}}, rd_half};
        wd_rep = {2{wdata_q[15:0]}};
        wr_be  = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        rd_ext = rd_word;
        wd_rep = wdata_q;
        wr_be  = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    load_rdata = 1'b0;
    busy_mem   = 1'b0;
    done_mem   = 1'b0;
    ram_be     = 4'b0000;
    ram_idx    = addr_q[ADDR_W-1:2];
    ram_wd     = wd_rep;
    case (state_q)
      IDLE: begin
        if (en_mem && aligned_mem) begin
          accept  = 1'b1;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        busy_mem = 1'b1;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        busy_mem = 1'b1;
        done_mem = 1'b1;
        if (wr_q == 2'b01) ram_be = wr_be;
        if (wr_q == 2'b10) load_rdata = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (!en_mem) state_d = IDLE;
      end
`ifdef MEM_RESP_INIT_EN
      INIT: begin
        busy_mem = 1'b1;
        ram_be   = 4'b1111;
        ram_idx  = init_idx;
        ram_wd   = 32'h0;
        if (init_idx == LAST_IDX) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RESET_STATE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wr_q      <= 2'b00;
      size_q    <= 2'b00;
      sign_q    <= 1'b0;
      wdata_q   <= 32'h0;
      rdata_mem <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr_mem;
        wr_q    <= W_R_mem;
        size_q  <= wordsize_mem;
        sign_q  <= sign_mem;
        wdata_q <= wdata_mem;
      end
      if (load_rdata) rdata_mem <= rd_ext;
    end
  end

`ifdef MEM_RESP_INIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) init_idx <= '0;
    else if (state_q == INIT) init_idx <= init_idx + 1'b1;
  end
`endif

  // RAM itself is never reset; only the ACCESS (or INIT) state drives byte enables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_be[i]) mem[ram_idx][8*i +: 8] <= ram_wd[8*i +: 8];
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder for the core's memory port: the target end of the `en_mem` / `W_R_mem` / `wordsize_mem` / `sign_mem` request interface driven by the control FSM. It checks alignment, accepts one request at a time, and inserts a programmable number of wait states. It then performs a byte, halfword or word read or write on an internal word-wide RAM and signals completion with `busy_mem` / `done_mem`. Read data is sign- or zero-extended to 32 bits.

## Interface
- `ADDR_W`, 12: byte-address width. RAM depth = 2^(ADDR_W-2) words of 32 bits.
- `LATENCY`, 2: wait states between acceptance and access. Legal range 0..15.

- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `en_mem`  in  1  request valid; level, held by initiator until `done_mem`
- `W_R_mem`  in  2  2'b01 write, 2'b10 read, 2'b00/2'b11 no-op
- `wordsize_mem`  in  2  2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 treated as word
- `sign_mem`  in  1  1 = sign-extend read data, 0 = zero-extend
- `addr_mem`  in  ADDR_W  byte address
- `wdata_mem`  in  32  store data, right-justified
- `rdata_mem`  out  32  extended load data
- `busy_mem`  out  1  request in progress
- `done_mem`  out  1  one-cycle completion pulse
- `aligned_mem`  out  1  combinational alignment of current `addr_mem` / `wordsize_mem`

## Operation
- `aligned_mem` rules:
  - Byte: always 1.
  - Half: `addr_mem[0]==0`.
  - Word: `addr_mem[1:0]==0`.
  - `aligned_mem` is independent of `en_mem` and state.
- States: IDLE, WAIT, ACCESS, HOLD (plus INIT under the config macro).
- IDLE:
  - `en_mem & aligned_mem` captures addr/W_R/size/sign/wdata, loads counter = LATENCY and goes to WAIT; if LATENCY==0 it goes to ACCESS.
  - A misaligned request is ignored: no busy, no done, RAM untouched. The initiator traps.
- WAIT: counter decrements each cycle. At 1 → ACCESS.
- ACCESS:
  - Read: word index = `addr[ADDR_W-1:2]`; lane selected by `addr[1:0]`; extended per captured size and sign. Result registered into `rdata_mem`.
  - Write: byte-enable write of the replicated store data. Byte lane `addr[1:0]`; half lanes `addr[1]`; word writes all four lanes. Other lanes are unchanged.
  - No-op: no RAM access.
  - All three cases pulse `done_mem` and go to HOLD.
- HOLD: waits for `en_mem==0`, then returns to IDLE. This prevents re-execution of a request still held high.
- Captured fields are used throughout. Input changes after acceptance have no effect.
- `rdata_mem` holds its value until the next completed read. Writes and no-ops do not change it.

## Timing
- Reset (async assert, sync release):
  - Outputs: `busy_mem=0`, `done_mem=0`, `rdata_mem=0`.
  - Counter = 0; state IDLE (INIT under the config macro).
- Acceptance at edge N (IDLE with `en_mem & aligned_mem`):
  - `busy_mem=1` from cycle N+1 through the ACCESS cycle.
  - `done_mem=1` in cycle N+1+LATENCY only.
- `rdata_mem` is valid in the cycle after `done_mem` rises and stays stable thereafter.
- `busy_mem` falls in the cycle after `done_mem`. It stays 0 in HOLD.
- Minimum spacing between accepted requests is LATENCY+3 cycles (one cycle of `en_mem` low included).
- `en_mem` dropping mid-request: the request still completes (abort not supported).
- Reset mid-operation: the request is discarded. A RAM write is performed only in ACCESS, so a reset before ACCESS leaves RAM unchanged.

## Configuration
- `MEM_RESP_INIT_EN` defined:
  - After reset release, the INIT state zeroes the RAM one word per cycle, for 2^(ADDR_W-2) cycles.
  - `busy_mem=1` throughout INIT; requests are ignored.
  - Then IDLE.
- Not defined: no INIT state; IDLE immediately after reset; RAM contents undefined until written.

## Test plan
- LATENCY=2, word write 0xDEADBEEF @0x010 then word read @0x010 → `done_mem` 3 cycles after each accept; `rdata_mem`=0xDEADBEEF.
- Byte write 0x80 @0x013 over word 0x00000000, then signed byte read @0x013 → 0xFFFFFF80; unsigned → 0x00000080; word read → 0x80000000.
- Signed half read @0x012 of word 0x8001_7FFF → 0xFFFF8001; half @0x011 → `aligned_mem=0`, no busy/done for 20 cycles, RAM unchanged.
- `en_mem` held high for 10 cycles after `done_mem` → exactly one access and one `done_mem`. Drop `en_mem` one cycle, re-raise → second request accepted.
- Reset pulsed during WAIT of a write → outputs cleared; a later read of that address returns its prior value.
- With `MEM_RESP_INIT_EN`, ADDR_W=6 → `busy_mem` high 16 cycles after reset release; every word reads 0.
